capture_ram_arbiter: RTL and testbench
======================================

Name: capture_ram_arbiter

Overview:
Shares the single-port capture row RAM between the capture writer (one 320-bit row per wr_ready pulse) and a readout requester. Each row is stored as two 160-bit RAM words: the high word at address 2*idx holds row[319:160], and the low word at 2*idx+1 holds row[159:0]. The block sits between the row assembler and the RAM primitive and sequences all RAM accesses.

Parameters:
ROW_WIDTH, 320, bits per captured row; must be even.
IDX_W, 8, row index width; RAM address width is IDX_W+1.
WORD_W, ROW_WIDTH/2, RAM data width (derived, not overridable).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_index  in  IDX_W  row index, valid with wr_ready
wr_data  in  ROW_WIDTH  row payload, valid with wr_ready
wr_ready  in  1  level; rising edge = new row available
wr_done  out  1  1-cycle pulse; both halves written
wr_overrun  out  1  1-cycle pulse; row dropped because buffer still pending
rd_req  in  1  level; held high until rd_ack
rd_index  in  IDX_W  row to read; stable while rd_req high
rd_ack  out  1  1-cycle pulse; rd_data valid
rd_data  out  ROW_WIDTH  last row read; held until next rd_ack
busy  out  1  state != IDLE
ram_address  out  IDX_W+1  RAM word address
ram_wdata  out  WORD_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  WORD_W  RAM read data; 1-cycle read latency

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; pending 0; last_grant=READ.
- Reset also sets wr_ready_q=1, so a row already asserted across reset is discarded.
- Reset mid-operation aborts the access immediately and drops ram_we. The buffered row is lost, and no wr_done or rd_ack is issued.
- Write capture:
  - A rising edge (wr_ready & ~wr_ready_q) with pending=0 latches wr_index/wr_data into the buffer and sets pending at the clock edge.
  - A rising edge with pending=1 keeps the old buffer and pulses wr_overrun the next cycle.
- States: IDLE, W_HI, W_LO, R_HI, R_LO, R_CAP.
- IDLE arbitration:
  - Write candidate = pending. Read candidate = rd_req & ~rd_ack; a read is never re-granted in the ack cycle.
  - If only one candidate is present, grant it.
  - If both are present, grant the one opposite last_grant, then update last_grant.
  - rd_index is latched on read grant.
- W_HI: ram_we=1, address={idx,0}, wdata=buf[ROW_WIDTH-1:WORD_W].
- W_LO: ram_we=1, address={idx,1}, wdata=buf[WORD_W-1:0].
- End of W_LO: clear pending, pulse wr_done next cycle, return to IDLE.
- An edge in the same cycle that pending clears is treated as pending=1, i.e. overrun.
- R_HI: address={ridx,0}, ram_we=0.
- R_LO: address={ridx,1}; capture ram_rdata into the high-half holding register.
- R_CAP: capture ram_rdata into the low half.
- Next cycle after R_CAP: rd_data updated, rd_ack=1, state IDLE.
- RAM outputs are decoded from registered state and registers only; there is no combinational input-to-RAM path.
- ram_address and ram_wdata are 0 whenever the state is IDLE.
- Latency, counting the cycle in which rd_req or the wr_ready edge is sampled as cycle 0:
  - Write: edge at cycle 0 → W_HI at cycle 2, W_LO at cycle 3, wr_done at cycle 4.
  - Read: grant at cycle 0 → rd_ack at cycle 4.
- Index range: the full 0..2^IDX_W-1 is valid; there is no address wrap beyond {idx,1}.

Decomposition:
- Package capture_pkg: ROW_WIDTH, IDX_W, WORD_W, state encoding constants, grant encoding.
- Sub-module capture_wr_latch: edge detect, row buffer, pending flag, overrun pulse.
- The arbiter FSM stays in the top module.

Test Plan:
1. Write only: wr_index=5, wr_data={160'hA.., 160'hB..}, wr_ready 0→1 → W_HI drives addr 10 / wdata A.. (we=1) at cycle 2, W_LO drives addr 11 / wdata B.. at cycle 3, wr_done pulses at cycle 4.
2. Read only: RAM model preloaded with addr 6=X, addr 7=Y; rd_req=1, rd_index=3 → addresses 6 and 7 issued with we=0, rd_ack at cycle 4, rd_data={X,Y}; rd_req held through the ack cycle → no second grant.
3. Simultaneous: pending write (idx 1) and rd_req (idx 2) in the same IDLE cycle after reset → write first; read granted in the IDLE cycle after W_LO; next tie → read wins.
4. Overrun: two wr_ready edges 3 cycles apart (idx 7 then idx 8) → one wr_overrun pulse; only idx 7 is written (addresses 14/15).
5. Reset mid-write: assert rst during W_HI → ram_we=0 immediately, no wr_done; after release, wr_ready still high → no write.
6. Boundary: idx 255 write then read → addresses 510/511, data round-trips intact.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared constants and encodings for the capture row RAM arbiter.
//   ROW_WIDTH : bits per captured row (even)
//   IDX_W     : row index width
//   WORD_W    : RAM word width, half a row
//   ADDR_W    : RAM word address width, one bit wider than the row index
package capture_pkg;

  localparam int unsigned ROW_WIDTH = 320;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned WORD_W    = ROW_WIDTH / 2;
  localparam int unsigned ADDR_W    = IDX_W + 1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWHi  = 3'd1,
    StWLo  = 3'd2,
    StRHi  = 3'd3,
    StRLo  = 3'd4,
    StRCap = 3'd5
  } state_e;

  typedef enum logic {
    GrantRead  = 1'b0,
    GrantWrite = 1'b1
  } grant_e;

  // High half of a row lives at the even word, low half at the odd word.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx, input logic lo);
    return {idx, lo};
  endfunction

endpackage

// File: rtl/capture_wr_latch.sv
// Write-side row buffer for the capture RAM arbiter.
// Detects rising edges of i_wr_ready, latches one row while none is pending and flags
// rows that arrive while the buffer is still occupied.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_wr_ready         : level, rising edge offers a new row
//   i_wr_index/data    : row index and payload, valid with i_wr_ready
//   i_clr_pending      : arbiter finished writing the buffered row
//   o_pending          : buffer holds a row not yet written
//   o_buf_index/data   : buffered row
//   o_overrun          : 1-cycle pulse, a row was dropped
module capture_wr_latch
  import capture_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_ready,
  input  logic [IDX_W-1:0]     i_wr_index,
  input  logic [ROW_WIDTH-1:0] i_wr_data,
  input  logic                 i_clr_pending,
  output logic                 o_pending,
  output logic [IDX_W-1:0]     o_buf_index,
  output logic [ROW_WIDTH-1:0] o_buf_data,
  output logic                 o_overrun
);

  logic                 r_wr_ready_q;
  logic                 r_pending;
  logic                 r_overrun;
  logic [IDX_W-1:0]     r_buf_index;
  logic [ROW_WIDTH-1:0] r_buf_data;
  logic                 w_edge;
  logic                 w_accept;

  assign w_edge   = i_wr_ready & ~r_wr_ready_q;
  // An edge in the cycle the buffer drains still sees it occupied and is dropped.
  assign w_accept = w_edge & ~r_pending;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Starting at 1 discards a row that was already offered across reset.
      r_wr_ready_q <= 1'b1;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_buf_index  <= '0;
      r_buf_data   <= '0;
    end else begin
      r_wr_ready_q <= i_wr_ready;
      r_overrun    <= w_edge & r_pending;
      r_pending    <= (r_pending & ~i_clr_pending) | w_accept;
      if (w_accept) begin
        r_buf_index <= i_wr_index;
        r_buf_data  <= i_wr_data;
      end
    end
  end

  assign o_pending   = r_pending;
  assign o_buf_index = r_buf_index;
  assign o_buf_data  = r_buf_data;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/capture_ram_arbiter.sv
// Sequences all accesses to the single-port capture row RAM between the row writer and
// a readout requester. Each row occupies two RAM words: high half at {idx,0}, low half
// at {idx,1}. RAM read latency is one cycle.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_wr_index/data/ready : row offer from the assembler (rising edge of ready)
//   o_wr_done             : 1-cycle pulse, both halves written
//   o_wr_overrun          : 1-cycle pulse, row dropped
//   i_rd_req/i_rd_index   : read request, held until o_rd_ack
//   o_rd_ack/o_rd_data    : read completion, data held until next ack
//   o_busy                : arbiter not idle
//   o_ram_*/i_ram_rdata   : RAM primitive interface
module capture_ram_arbiter
  import capture_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [IDX_W-1:0]     i_wr_index,
  input  logic [ROW_WIDTH-1:0] i_wr_data,
  input  logic                 i_wr_ready,
  output logic                 o_wr_done,
  output logic                 o_wr_overrun,
  input  logic                 i_rd_req,
  input  logic [IDX_W-1:0]     i_rd_index,
  output logic                 o_rd_ack,
  output logic [ROW_WIDTH-1:0] o_rd_data,
  output logic                 o_busy,
  output logic [ADDR_W-1:0]    o_ram_address,
  output logic [WORD_W-1:0]    o_ram_wdata,
  output logic                 o_ram_we,
  input  logic [WORD_W-1:0]    i_ram_rdata
);

  state_e               r_state;
  state_e               w_state_next;
  grant_e               r_last_grant;
  logic [IDX_W-1:0]     r_rd_index;
  logic [WORD_W-1:0]    r_rd_hi;
  logic [ROW_WIDTH-1:0] r_rd_data;
  logic                 r_rd_ack;
  logic                 r_wr_done;

  logic                 w_pending;
  logic [IDX_W-1:0]     w_buf_index;
  logic [ROW_WIDTH-1:0] w_buf_data;
  logic                 w_clr_pending;
  logic                 w_rd_cand;
  logic                 w_tie;

  assign w_clr_pending = (r_state == StWLo);

  capture_wr_latch u_wr_latch (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_ready    (i_wr_ready),
    .i_wr_index    (i_wr_index),
    .i_wr_data     (i_wr_data),
    .i_clr_pending (w_clr_pending),
    .o_pending     (w_pending),
    .o_buf_index   (w_buf_index),
    .o_buf_data    (w_buf_data),
    .o_overrun     (o_wr_overrun)
  );

  // The still-high request in the ack cycle belongs to the read just completed.
  assign w_rd_cand = i_rd_req & ~r_rd_ack;
  assign w_tie     = (r_state == StIdle) & w_pending & w_rd_cand;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_tie) begin
          w_state_next = (r_last_grant == GrantRead) ? StWHi : StRHi;
        end else if (w_pending) begin
          w_state_next = StWHi;
        end else if (w_rd_cand) begin
          w_state_next = StRHi;
        end
      end
      StWHi:   w_state_next = StWLo;
      StWLo:   w_state_next = StIdle;
      StRHi:   w_state_next = StRLo;
      StRLo:   w_state_next = StRCap;
      StRCap:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_ram_we      = 1'b0;
    o_ram_address = '0;
    o_ram_wdata   = '0;
    o_busy        = (r_state != StIdle);
    unique case (r_state)
      StIdle: begin
      end
      StWHi: begin
        o_ram_we      = 1'b1;
        o_ram_address = word_addr(w_buf_index, 1'b0);
        o_ram_wdata   = w_buf_data[ROW_WIDTH-1:WORD_W];
      end
      StWLo: begin
        o_ram_we      = 1'b1;
        o_ram_address = word_addr(w_buf_index, 1'b1);
        o_ram_wdata   = w_buf_data[WORD_W-1:0];
      end
      StRHi: begin
        o_ram_address = word_addr(r_rd_index, 1'b0);
      end
      StRLo, StRCap: begin
        o_ram_address = word_addr(r_rd_index, 1'b1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= GrantRead;
      r_rd_index   <= '0;
      r_rd_hi      <= '0;
      r_rd_data    <= '0;
      r_rd_ack     <= 1'b0;
      r_wr_done    <= 1'b0;
    end else begin
      r_rd_ack  <= (r_state == StRCap);
      r_wr_done <= (r_state == StWLo);
      if ((r_state == StIdle) && (w_state_next == StRHi)) begin
        r_rd_index <= i_rd_index;
      end
      // Fairness only matters when both sides compete.
      if (w_tie) begin
        r_last_grant <= (w_state_next == StWHi) ? GrantWrite : GrantRead;
      end
      if (r_state == StRLo) begin
        r_rd_hi <= i_ram_rdata;
      end
      if (r_state == StRCap) begin
        r_rd_data <= {r_rd_hi, i_ram_rdata};
      end
    end
  end

  assign o_rd_ack  = r_rd_ack;
  assign o_rd_data = r_rd_data;
  assign o_wr_done = r_wr_done;

endmodule

// File: tb/tb_capture_ram_arbiter.sv
// Self-checking bench for capture_ram_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a transaction-level model of the arbiter.
module tb_capture_ram_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   wr_index;
  logic [319:0] wr_data;
  logic         wr_ready;
  logic         wr_done;
  logic         wr_overrun;
  logic         rd_req;
  logic [7:0]   rd_index;
  logic         rd_ack;
  logic [319:0] rd_data;
  logic         busy;
  logic [8:0]   ram_address;
  logic [159:0] ram_wdata;
  logic         ram_we;
  logic [159:0] ram_rdata;

  always #5 clk = ~clk;

  capture_ram_arbiter dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_index    (wr_index),
    .i_wr_data     (wr_data),
    .i_wr_ready    (wr_ready),
    .o_wr_done     (wr_done),
    .o_wr_overrun  (wr_overrun),
    .i_rd_req      (rd_req),
    .i_rd_index    (rd_index),
    .o_rd_ack      (rd_ack),
    .o_rd_data     (rd_data),
    .o_busy        (busy),
    .o_ram_address (ram_address),
    .o_ram_wdata   (ram_wdata),
    .o_ram_we      (ram_we),
    .i_ram_rdata   (ram_rdata)
  );

  // Single-port RAM primitive, registered read.
  logic [159:0] mem [0:511];
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_wdata;
    ram_rdata <= mem[ram_address];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Rows as the RAM should hold them, one entry per index.
  logic [319:0] shadow [0:255];
  bit           m_pend;
  logic [7:0]   m_bidx;
  logic [319:0] m_bdata;
  bit           m_prev;
  bit           m_last_w;
  bit           m_ovr;
  logic [319:0] m_rd_data;
  // Most recent granted access: a write occupies grant+1..grant+2 and completes at
  // grant+3; a read occupies grant+1..grant+3 and acks at grant+4.
  bit           op_v;
  bit           op_w;
  int           op_g;
  logic [7:0]   op_idx;
  logic [319:0] op_data;
  int           x_k;
  bit           x_we, x_busy, x_done, x_ack;

  task automatic model_reset();
    m_pend = 0; m_prev = 1; m_last_w = 0; m_ovr = 0; m_rd_data = '0; op_v = 0;
  endtask

  task automatic compute_exp();
    x_k    = cyc - op_g;
    x_we   = op_v && op_w && (x_k == 1 || x_k == 2);
    x_busy = op_v && (x_k >= 1) && (op_w ? (x_k <= 2) : (x_k <= 3));
    x_done = op_v && op_w && (x_k == 3);
    x_ack  = op_v && !op_w && (x_k == 4);
  endtask

  task automatic check_cycle();
    logic [8:0] e_addr;
    compute_exp();
    if (x_ack) m_rd_data = op_data;
    check_eq("ram_we", ram_we, x_we);
    check_eq("busy", busy, x_busy);
    check_eq("wr_done", wr_done, x_done);
    check_eq("wr_overrun", wr_overrun, m_ovr);
    check_eq("rd_ack", rd_ack, x_ack);
    check_eq("rd_data", rd_data, m_rd_data);
    if (x_busy && (x_k == 1 || x_k == 2)) begin
      e_addr = {op_idx, (x_k == 2)};
      check_eq("ram_address", ram_address, e_addr);
    end else if (!x_busy) begin
      check_eq("ram_address_idle", ram_address, 0);
    end
    if (x_we) begin
      check_eq("ram_wdata", ram_wdata, (x_k == 1) ? op_data[319:160] : op_data[159:0]);
    end else if (!x_busy) begin
      check_eq("ram_wdata_idle", ram_wdata, 0);
    end
  endtask

  task automatic advance(input logic rdy, input logic [7:0] widx, input logic [319:0] wdat,
                         input logic req, input logic [7:0] ridx);
    bit edge_s, clr, wc, rc, gw;
    edge_s = rdy && !m_prev;
    m_prev = rdy;
    clr = op_v && op_w && (x_k == 2);
    if (clr) shadow[op_idx] = op_data;
    if (!x_busy) begin
      wc = m_pend;
      rc = req && !x_ack;
      if (wc && rc) begin
        gw = !m_last_w;
        m_last_w = gw;
      end else begin
        gw = wc;
      end
      if (wc || rc) begin
        op_v = 1; op_g = cyc; op_w = gw;
        op_idx  = gw ? m_bidx : ridx;
        op_data = gw ? m_bdata : shadow[ridx];
      end
    end
    m_ovr = edge_s && m_pend;
    if (edge_s && !m_pend) begin
      m_pend = 1; m_bidx = widx; m_bdata = wdat;
    end else if (clr) begin
      m_pend = 0;
    end
  endtask

  task automatic step(input logic rdy, input logic [7:0] widx, input logic [319:0] wdat,
                      input logic req, input logic [7:0] ridx);
    check_cycle();
    wr_ready = rdy; wr_index = widx; wr_data = wdat; rd_req = req; rd_index = ridx;
    advance(rdy, widx, wdat, req, ridx);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, '0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_ready = 1'b0; rd_req = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_cycle();
    rst = 1'b0;
  endtask

  function automatic logic [319:0] rand_row();
    logic [319:0] r;
    for (int j = 0; j < 10; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] rand_idx();
    int unsigned s;
    s = $urandom_range(0, 7);
    if (s == 0) return 8'd0;
    if (s == 1) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  logic [319:0] d_ab;
  logic         rr, rq;
  logic [7:0]   rwi, rri;
  logic [319:0] rwd;
  bit           drop;

  initial begin
    wr_ready = 0; wr_index = 0; wr_data = '0; rd_req = 0; rd_index = 0;
    for (int i = 0; i < 256; i++) begin
      shadow[i] = rand_row();
      mem[2*i]   = shadow[i][319:160];
      mem[2*i+1] = shadow[i][159:0];
    end
    d_ab = {{5{32'hAAAA_AAAA}}, {5{32'hBBBB_BBBB}}};
    do_reset();
    cyc = 0;

    // Write only, idx 5.
    idle(1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'd5, d_ab, 1'b0, 8'd0);
    idle(2);

    // Read only, idx 3, request held through the ack cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 8'd0, '0, 1'b1, 8'd3);
    idle(2);

    // Simultaneous write and read after reset, then a second tie.
    do_reset();
    idle(1);
    step(1'b1, 8'd1, rand_row(), 1'b0, 8'd2);
    for (int i = 0; i < 8; i++) step(1'b1, 8'd1, '0, 1'b1, 8'd2);
    idle(1);
    rwd = rand_row();
    step(1'b1, 8'd4, rwd, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'd4, rwd, 1'b1, 8'd9);
    for (int i = 0; i < 6; i++) step(1'b1, 8'd4, rwd, 1'b0, 8'd0);
    idle(1);

    // Overrun: edges three cycles apart.
    rwd = rand_row();
    step(1'b1, 8'd7, rwd, 1'b0, 8'd0);
    idle(2);
    for (int i = 0; i < 6; i++) step(1'b1, 8'd8, rand_row(), 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'd0, '0, 1'b1, 8'd7);
    for (int i = 0; i < 5; i++) step(1'b0, 8'd0, '0, 1'b1, 8'd8);
    idle(1);

    // Reset during W_HI, wr_ready held high across it.
    rwd = rand_row();
    step(1'b1, 8'd9, rwd, 1'b0, 8'd0);
    step(1'b1, 8'd9, rwd, 1'b0, 8'd0);
    check_cycle();
    rst = 1'b1;
    #1;
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ram_address", ram_address, 0);
    @(negedge clk);
    check_eq("rst_wr_done", wr_done, 0);
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'd9, rwd, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'd9, rwd, 1'b1, 8'd9);
    idle(1);

    // Highest index round trip.
    rwd = rand_row();
    step(1'b1, 8'd255, rwd, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'd255, rwd, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'd0, '0, 1'b1, 8'd255);
    idle(1);

    // Random traffic.
    rr = 0; rq = 0; rwi = 0; rri = 0; rwd = '0; drop = 0;
    for (int i = 0; i < 3000; i++) begin
      compute_exp();
      if (drop) begin
        rq = 0;
        drop = 0;
      end else if (!rq && $urandom_range(0, 3) == 0) begin
        rq = 1;
        rri = rand_idx();
      end
      if (rq && x_ack) drop = 1;
      if ($urandom_range(0, 3) == 0) begin
        if (!rr) begin
          rwi = rand_idx();
          rwd = rand_row();
        end
        rr = !rr;
      end
      step(rr, rwi, rwd, rq, rri);
    end
    for (int i = 0; i < 8; i++) step(rr, rwi, rwd, 1'b0, 8'd0);

    for (int i = 0; i < 256; i++) begin
      check_eq("mem_hi", mem[2*i], shadow[i][319:160]);
      check_eq("mem_lo", mem[2*i+1], shadow[i][159:0]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
